call_ret_ctrl: RTL and testbench

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

---
 rtl/call_ret_ctrl.sv | 138 +++++++++++++
 tb/tb_call_ret_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/call_ret_ctrl.sv
// Call/return controller: saves a 16-bit return address as two pushed bytes
// on call. On return it pops the high byte and then the low byte, and
// reassembles the address on pc_o. All stack-facing outputs are registered,
// so each opcode lines up with the state that owns it.
module call_ret_ctrl #(
  parameter int         MAX_DEPTH = 128,
  parameter logic [3:0] OP_PUSH   = 4'b1101,
  parameter logic [3:0] OP_POP    = 4'b1111,
  parameter logic [3:0] OP_NOP    = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [15:0] ret_addr_i,
  input  logic [7:0]  stack_data_i,
  output logic [3:0]  stack_opcode,
  output logic [7:0]  stack_data_o,
  output logic        busy,
  output logic        call_done,
  output logic [15:0] pc_o,
  output logic        pc_valid,
  output logic        overflow,
  output logic        underflow,
  output logic [7:0]  depth
);

  typedef enum logic [2:0] {
    IDLE, PUSH_LO, PUSH_HI, POP_HI, POP_LO, POP_WAIT
  } state_t;

  localparam logic [8:0] MAX_D = 9'(MAX_DEPTH);

  state_t      state, state_d;
  logic [3:0]  op_d;
  logic [7:0]  data_d;
  logic        done_d, valid_d, ovf_d, unf_d;
  logic [7:0]  depth_d;
  logic [15:0] pc_d;
  logic [7:0]  addr_hi, addr_hi_d;
  logic [7:0]  pc_hi, pc_hi_d;

  assign busy = (state != IDLE);

  // Next state plus the values every registered output takes in that state.
  // The opcode is computed one edge early so it is live while its state is.
  always_comb begin
    state_d   = state;
    op_d      = OP_NOP;
    data_d    = 8'h00;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    depth_d   = depth;
    pc_d      = pc_o;
    addr_hi_d = addr_hi;
    pc_hi_d   = pc_hi;
    case (state)
      IDLE: begin
        // A call wins over a simultaneous return; the return is dropped.
        if (call_req) begin
          if ({1'b0, depth} < MAX_D) begin
            addr_hi_d = ret_addr_i[15:8];
            data_d    = ret_addr_i[7:0];
            op_d      = OP_PUSH;
            state_d   = PUSH_LO;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (ret_req) begin
          if (depth != 8'd0) begin
            op_d    = OP_POP;
            state_d = POP_HI;
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      PUSH_LO: begin
        op_d    = OP_PUSH;
        data_d  = addr_hi;
        state_d = PUSH_HI;
      end
      PUSH_HI: begin
        done_d  = 1'b1;
        depth_d = depth + 8'd1;
        state_d = IDLE;
      end
      POP_HI: begin
        op_d    = OP_POP;
        state_d = POP_LO;
      end
      POP_LO: begin
        // Read data for the first pop (high byte) is valid this cycle.
        pc_hi_d = stack_data_i;
        state_d = POP_WAIT;
      end
      POP_WAIT: begin
        pc_d    = {pc_hi, stack_data_i};
        valid_d = 1'b1;
        depth_d = depth - 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stack_opcode <= OP_NOP;
      stack_data_o <= 8'h00;
      call_done    <= 1'b0;
      pc_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      depth        <= 8'd0;
      pc_o         <= 16'h0000;
      addr_hi      <= 8'h00;
      pc_hi        <= 8'h00;
    end else begin
      state        <= state_d;
      stack_opcode <= op_d;
      stack_data_o <= data_d;
      call_done    <= done_d;
      pc_valid     <= valid_d;
      overflow     <= ovf_d;
      underflow    <= unf_d;
      depth        <= depth_d;
      pc_o         <= pc_d;
      addr_hi      <= addr_hi_d;
      pc_hi        <= pc_hi_d;
    end
  end

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed bench for call_ret_ctrl with a small behavioural byte stack.
// A second instance with MAX_DEPTH=2 shares the inputs for the overflow case.
module tb_call_ret_ctrl;
  localparam logic [3:0] PUSH = 4'b1101, POP = 4'b1111, NOP = 4'b0000;

  logic        clk = 1'b0;
  logic        rst, call_req, ret_req;
  logic [15:0] ret_addr_i;
  logic [7:0]  stack_data_i;
  logic [3:0]  stack_opcode, op2;
  logic [7:0]  stack_data_o, data2, depth, depth2;
  logic        busy, call_done, pc_valid, overflow, underflow;
  logic        busy2, done2, valid2, ovf2, unf2;
  logic [15:0] pc_o, pc2;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  call_ret_ctrl dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .ret_addr_i(ret_addr_i), .stack_data_i(stack_data_i),
    .stack_opcode(stack_opcode), .stack_data_o(stack_data_o), .busy(busy),
    .call_done(call_done), .pc_o(pc_o), .pc_valid(pc_valid),
    .overflow(overflow), .underflow(underflow), .depth(depth));

  call_ret_ctrl #(.MAX_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .ret_addr_i(ret_addr_i), .stack_data_i(stack_data_i),
    .stack_opcode(op2), .stack_data_o(data2), .busy(busy2),
    .call_done(done2), .pc_o(pc2), .pc_valid(valid2),
    .overflow(ovf2), .underflow(unf2), .depth(depth2));

  // Behavioural stack driven by the main instance; pop data appears next cycle.
  logic [7:0] mem [0:255];
  int sp = 0;
  always @(posedge clk) begin
    if (rst) begin
      sp <= 0;
      stack_data_i <= 8'h00;
    end else if (stack_opcode == PUSH) begin
      mem[sp[7:0]] <= stack_data_o;
      sp <= sp + 1;
    end else if (stack_opcode == POP) begin
      stack_data_i <= mem[8'(sp - 1)];
      sp <= sp - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic do_call(input logic [15:0] a);
    call_req = 1'b1; ret_addr_i = a; step(); call_req = 1'b0;
    step(2);
  endtask

  // Issue a return and check pc_valid lands exactly 3 cycles after acceptance.
  task automatic do_ret(input string tag, input logic [15:0] exp_pc, input logic [7:0] exp_d);
    ret_req = 1'b1; step(); ret_req = 1'b0;
    chk({tag, "_op_hi"}, stack_opcode, POP);
    step();
    chk({tag, "_op_lo"}, stack_opcode, POP);
    step();
    chk({tag, "_op_wait"}, stack_opcode, NOP);
    chk({tag, "_valid_early"}, pc_valid, 1'b0);
    step();
    chk({tag, "_valid"}, pc_valid, 1'b1);
    chk({tag, "_pc"}, pc_o, exp_pc);
    chk({tag, "_depth"}, depth, exp_d);
  endtask

  initial begin
    rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; ret_addr_i = 16'h0;
    step(2); rst = 1'b0;
    chk("rst_op", stack_opcode, NOP);
    chk("rst_data", stack_data_o, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_depth", depth, 8'd0);
    chk("rst_pc", pc_o, 16'h0);
    chk("rst_pulses", {call_done, pc_valid, overflow, underflow}, 4'b0);

    // Single call; a return request while busy must be ignored.
    call_req = 1'b1; ret_addr_i = 16'hA55A; step(); call_req = 1'b0;
    chk("c1_op_lo", stack_opcode, PUSH);
    chk("c1_data_lo", stack_data_o, 8'h5A);
    chk("c1_busy", busy, 1'b1);
    ret_req = 1'b1; step(); ret_req = 1'b0;
    chk("c1_op_hi", stack_opcode, PUSH);
    chk("c1_data_hi", stack_data_o, 8'hA5);
    chk("c1_done_early", call_done, 1'b0);
    step();
    chk("c1_done", call_done, 1'b1);
    chk("c1_depth", depth, 8'd1);
    chk("c1_idle_op", stack_opcode, NOP);
    chk("c1_idle_busy", busy, 1'b0);
    step();
    chk("c1_done_pulse", call_done, 1'b0);
    chk("c1_busy_ignored", stack_opcode, NOP);

    // Two nested calls, two returns in LIFO order.
    do_reset();
    do_call(16'h1234);
    do_call(16'hBEEF);
    chk("n_depth2", depth, 8'd2);
    do_ret("r1", 16'hBEEF, 8'd1);
    do_ret("r2", 16'h1234, 8'd0);
    step();
    chk("r2_valid_pulse", pc_valid, 1'b0);

    // Return at depth 0.
    ret_req = 1'b1; step(); ret_req = 1'b0;
    chk("uf_pulse", underflow, 1'b1);
    chk("uf_op", stack_opcode, NOP);
    chk("uf_busy", busy, 1'b0);
    step();
    chk("uf_pulse_end", underflow, 1'b0);
    chk("uf_depth", depth, 8'd0);

    // Simultaneous call and return at depth 1: call wins.
    do_call(16'h0F0F);
    call_req = 1'b1; ret_req = 1'b1; ret_addr_i = 16'hC3D4; step();
    call_req = 1'b0; ret_req = 1'b0;
    chk("cr_op", stack_opcode, PUSH);
    chk("cr_data", stack_data_o, 8'hD4);
    step(2);
    chk("cr_depth", depth, 8'd2);
    chk("cr_done", call_done, 1'b1);
    chk("cr_pc_kept", pc_o, 16'h1234);

    // Reset while in POP_LO aborts the return.
    ret_req = 1'b1; step(); ret_req = 1'b0;
    step();
    chk("ra_in_poplo", stack_opcode, POP);
    rst = 1'b1; step(); rst = 1'b0;
    chk("ra_op", stack_opcode, NOP);
    chk("ra_busy", busy, 1'b0);
    chk("ra_valid", pc_valid, 1'b0);
    chk("ra_depth", depth, 8'd0);
    chk("ra_pc", pc_o, 16'h0);
    step();
    chk("ra_op_after", stack_opcode, NOP);
    chk("ra_valid_after", pc_valid, 1'b0);

    // Overflow on the MAX_DEPTH=2 instance.
    do_reset();
    do_call(16'h1111);
    do_call(16'h2222);
    chk("of_depth_pre", depth2, 8'd2);
    call_req = 1'b1; ret_addr_i = 16'h3333; step(); call_req = 1'b0;
    chk("of_pulse", ovf2, 1'b1);
    chk("of_op", op2, NOP);
    chk("of_busy", busy2, 1'b0);
    step();
    chk("of_pulse_end", ovf2, 1'b0);
    chk("of_op_after", op2, NOP);
    chk("of_depth", depth2, 8'd2);
    chk("of_main_accepts", depth, 8'd2);
    step();
    chk("of_main_depth", depth, 8'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
